hub75_capture: RTL and testbench

Panel-side receiver for the HUB75-style LED matrix bus (rgb0/rgb1, rgb_clk, rgb_stb, oe_n, demux) produced by the team's matrix driver. It emulates the panel's column shift registers and output latches, then integrates the on-time of every pixel channel into an accumulator RAM. The RAM is readable through a simple synchronous port. The block serves as an in-FPGA loopback monitor and as a self-checking bench component for PWM/brightness verification, and it flags protocol violations.

---
 rtl/hub75_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_hub75_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// HUB75 panel-side receiver: emulates the column shift/latch registers and integrates
// per-pixel on-time into a saturating accumulator RAM with a synchronous read port.
module hub75_capture #(
  parameter int unsigned COLS  = 32,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned ON_W  = 16,
  localparam int unsigned ColW  = $clog2(COLS),
  localparam int unsigned AddrW = 3 + ColW
) (
  input  logic               led_clk,
  input  logic               rsi_reset_n,
  input  logic [2:0]         demux,
  input  logic [2:0]         rgb0,
  input  logic [2:0]         rgb1,
  input  logic               rgb_clk,
  input  logic               rgb_stb,
  input  logic               oe_n,
  input  logic               clr,
  input  logic               err_clr,
  input  logic [AddrW-1:0]   rd_addr,
  output logic [6*ACC_W-1:0] rd_data,
  output logic               busy,
  output logic [2:0]         err,
  output logic [15:0]        window_cnt
);

  localparam int unsigned Depth = 1 << AddrW;
  localparam int unsigned DataW = 6 * ACC_W;
  localparam int unsigned SumW  = ((ACC_W > ON_W) ? ACC_W : ON_W) + 1;
  localparam logic [5:0]      ColsCnt = 6'(COLS);
  localparam logic [SumW-1:0] AccMax  = SumW'({ACC_W{1'b1}});

  typedef enum logic [1:0] {StClear, StIdle, StDisplay, StUpdate} state_e;
  state_e state_q, state_d;

  logic [2:0] demux_q, rgb0_q, rgb1_q;
  logic       rgb_clk_q, rgb_stb_q, oe_n_q;
  logic       rgb_clk_prev_q, rgb_stb_prev_q, oe_n_prev_q;

  logic [COLS-1:0][5:0] sr_q, sr_d, lat_q, lat_d, snap_q, snap_d;
  logic [5:0]       shcnt_q, shcnt_d, shcnt_sh;
  logic [2:0]       row_q, row_d;
  logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
  logic [ColW-1:0]  col_q, col_d;
  logic             wr_ph_q, wr_ph_d;
  logic [AddrW-1:0] clr_addr_q, clr_addr_d;
  logic             clr_pend_q, clr_pend_d;
  logic [2:0]       err_q, err_d;
  logic [15:0]      win_cnt_q, win_cnt_d;
  logic [DataW-1:0] acc_rd_q, rd_data_q;

  logic             shift_ev, latch_ev, oe_fall, upd_last;
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr, upd_addr;
  logic [DataW-1:0] mem_wdata, acc_sum;
  logic [5:0]       cur_pix;
  logic [SumW-1:0]  ch_sum;

  logic [DataW-1:0] mem_q [Depth];

  assign shift_ev = rgb_clk_q & ~rgb_clk_prev_q;
  assign latch_ev = rgb_stb_q & ~rgb_stb_prev_q;
  assign oe_fall  = ~oe_n_q & oe_n_prev_q;
  assign upd_last = wr_ph_q && (col_q == '1);
  assign upd_addr = {row_q, col_q};

  // Shift is applied before a same-cycle latch, so lat and shcnt see the new column.
  always_comb begin
    sr_d     = sr_q;
    lat_d    = lat_q;
    shcnt_sh = shcnt_q;
    if (shift_ev) begin
      for (int i = 0; i < int'(COLS) - 1; i++) sr_d[i] = sr_q[i+1];
      sr_d[COLS-1] = {rgb0_q, rgb1_q};
      if (shcnt_q != 6'd63) shcnt_sh = shcnt_q + 6'd1;
    end
    shcnt_d = shcnt_sh;
    if (latch_ev) begin
      lat_d   = sr_d;
      shcnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear:   if (clr_addr_q == '1) state_d = StIdle;
      StIdle:    if (clr) state_d = StClear;
                 else if (oe_fall) state_d = StDisplay;
      StDisplay: if (oe_n_q) state_d = StUpdate;
      StUpdate:  if (upd_last) state_d = (clr_pend_q || clr) ? StClear : StIdle;
      default:   state_d = StClear;
    endcase
  end

  always_comb begin
    row_d      = row_q;
    snap_d     = snap_q;
    on_cnt_d   = on_cnt_q;
    col_d      = col_q;
    wr_ph_d    = wr_ph_q;
    clr_addr_d = clr_addr_q;
    clr_pend_d = clr_pend_q;
    win_cnt_d  = win_cnt_q;
    err_d      = err_clr ? 3'b000 : err_q;
    unique case (state_q)
      StClear: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) clr_pend_d = 1'b0;
      end
      StIdle: begin
        if (!clr && oe_fall) begin
          row_d    = demux_q;
          snap_d   = lat_q;
          on_cnt_d = ON_W'(1);
        end
      end
      StDisplay: begin
        if (!oe_n_q) begin
          if (on_cnt_q != '1) on_cnt_d = on_cnt_q + 1'b1;
        end else begin
          col_d   = '0;
          wr_ph_d = 1'b0;
        end
      end
      StUpdate: begin
        wr_ph_d = ~wr_ph_q;
        if (wr_ph_q) begin
          col_d = col_q + 1'b1;
          if (col_q == '1) win_cnt_d = win_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
    if (clr && (state_q == StDisplay || state_q == StUpdate)) clr_pend_d = 1'b1;
    if (latch_ev && (shcnt_sh != ColsCnt)) err_d[0] = 1'b1;
    if (state_q == StUpdate && oe_fall) err_d[1] = 1'b1;
    if (state_q == StDisplay && latch_ev) err_d[2] = 1'b1;
  end

  always_comb begin
    acc_sum = '0;
    ch_sum  = '0;
    cur_pix = snap_q[col_q];
    for (int k = 0; k < 6; k++) begin
      ch_sum = SumW'(acc_rd_q[k*ACC_W +: ACC_W]) + (cur_pix[k] ? SumW'(on_cnt_q) : '0);
      acc_sum[k*ACC_W +: ACC_W] = (ch_sum > AccMax) ? {ACC_W{1'b1}} : ch_sum[ACC_W-1:0];
    end
  end

  always_comb begin
    busy      = (state_q == StClear);
    mem_we    = 1'b0;
    mem_waddr = clr_addr_q;
    mem_wdata = '0;
    unique case (state_q)
      StClear:  mem_we = 1'b1;
      StUpdate: begin
        if (wr_ph_q) begin
          mem_we    = 1'b1;
          mem_waddr = upd_addr;
          mem_wdata = acc_sum;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge led_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) state_q <= StClear;
    else              state_q <= state_d;
  end

  always_ff @(posedge led_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      demux_q        <= '0;
      rgb0_q         <= '0;
      rgb1_q         <= '0;
      rgb_clk_q      <= 1'b0;
      rgb_stb_q      <= 1'b0;
      oe_n_q         <= 1'b1;
      rgb_clk_prev_q <= 1'b0;
      rgb_stb_prev_q <= 1'b0;
      oe_n_prev_q    <= 1'b1;
      sr_q           <= '0;
      lat_q          <= '0;
      snap_q         <= '0;
      shcnt_q        <= '0;
      row_q          <= '0;
      on_cnt_q       <= '0;
      col_q          <= '0;
      wr_ph_q        <= 1'b0;
      clr_addr_q     <= '0;
      clr_pend_q     <= 1'b0;
      err_q          <= '0;
      win_cnt_q      <= '0;
      rd_data_q      <= '0;
    end else begin
      demux_q        <= demux;
      rgb0_q         <= rgb0;
      rgb1_q         <= rgb1;
      rgb_clk_q      <= rgb_clk;
      rgb_stb_q      <= rgb_stb;
      oe_n_q         <= oe_n;
      rgb_clk_prev_q <= rgb_clk_q;
      rgb_stb_prev_q <= rgb_stb_q;
      oe_n_prev_q    <= oe_n_q;
      sr_q           <= sr_d;
      lat_q          <= lat_d;
      snap_q         <= snap_d;
      shcnt_q        <= shcnt_d;
      row_q          <= row_d;
      on_cnt_q       <= on_cnt_d;
      col_q          <= col_d;
      wr_ph_q        <= wr_ph_d;
      clr_addr_q     <= clr_addr_d;
      clr_pend_q     <= clr_pend_d;
      err_q          <= err_d;
      win_cnt_q      <= win_cnt_d;
      rd_data_q      <= mem_q[rd_addr];
    end
  end

  // Accumulator RAM: no reset, contents are defined by the CLEAR sweep.
  always_ff @(posedge led_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    acc_rd_q <= mem_q[upd_addr];
  end

  assign rd_data    = rd_data_q;
  assign err        = err_q;
  assign window_cnt = win_cnt_q;

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: a 20-bit and an 8-bit accumulator instance share
// one bus; expected RAM contents are built from the pixel pattern and on-time.
module tb_hub75_capture;

  logic         led_clk;
  logic         rsi_reset_n;
  logic [2:0]   demux, rgb0, rgb1;
  logic         rgb_clk, rgb_stb, oe_n, clr, err_clr;
  logic [7:0]   rd_addr;
  logic [119:0] rd_data;
  logic [47:0]  rd_data8;
  logic         busy, busy8;
  logic [2:0]   err, err8;
  logic [15:0]  window_cnt, window_cnt8;

  int total = 0;
  int bad   = 0;

  hub75_capture #(.COLS(32), .ACC_W(20), .ON_W(16)) u_dut (
    .led_clk(led_clk), .rsi_reset_n(rsi_reset_n), .demux(demux), .rgb0(rgb0),
    .rgb1(rgb1), .rgb_clk(rgb_clk), .rgb_stb(rgb_stb), .oe_n(oe_n), .clr(clr),
    .err_clr(err_clr), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err(err),
    .window_cnt(window_cnt)
  );

  hub75_capture #(.COLS(32), .ACC_W(8), .ON_W(16)) u_dut8 (
    .led_clk(led_clk), .rsi_reset_n(rsi_reset_n), .demux(demux), .rgb0(rgb0),
    .rgb1(rgb1), .rgb_clk(rgb_clk), .rgb_stb(rgb_stb), .oe_n(oe_n), .clr(clr),
    .err_clr(err_clr), .rd_addr(rd_addr), .rd_data(rd_data8), .busy(busy8), .err(err8),
    .window_cnt(window_cnt8)
  );

  initial led_clk = 1'b0;
  always #5 led_clk = ~led_clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge led_clk);
    #1;
  endtask

  task automatic shift_col(input logic [5:0] pix);
    rgb0    = pix[5:3];
    rgb1    = pix[2:0];
    rgb_clk = 1'b1;
    tick(1);
    rgb_clk = 1'b0;
    tick(1);
  endtask

  task automatic strobe();
    rgb_stb = 1'b1;
    tick(1);
    rgb_stb = 1'b0;
    tick(1);
  endtask

  function automatic logic [5:0] pat_pix(input int c);
    logic [2:0] c3;
    c3 = c[2:0];
    return {c3, ~c3};
  endfunction

  task automatic load_pattern();
    for (int c = 0; c < 32; c++) shift_col(pat_pix(c));
    strobe();
    tick(2);
  endtask

  function automatic logic [127:0] build(input logic [5:0] pix, input int v, input int w);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) if (pix[k]) r = r | (128'(v) << (k * w));
    return r;
  endfunction

  // Reads every address from both instances; rows ra/rb hold value va/vb per set bit.
  task automatic check_mem(input string tag, input int ra, input int va, input int rb,
                           input int vb, input bit white);
    int r, c, v, v8;
    logic [5:0] pix;
    for (int a = 0; a < 256; a++) begin
      r   = a / 32;
      c   = a % 32;
      pix = white ? 6'h3f : pat_pix(c);
      v   = (r == ra) ? va : ((r == rb) ? vb : 0);
      v8  = (v > 255) ? 255 : v;
      rd_addr = a[7:0];
      tick(1);
      check_eq($sformatf("%s[%0d]", tag, a), {8'h0, rd_data}, build(pix, v, 20));
      check_eq($sformatf("%s8[%0d]", tag, a), {80'h0, rd_data8}, build(pix, v8, 8));
    end
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      tick(1);
    end
    check_eq(tag, 128'(cnt), 128'(256));
  endtask

  initial begin
    rsi_reset_n = 1'b0;
    demux = '0; rgb0 = '0; rgb1 = '0;
    rgb_clk = 1'b0; rgb_stb = 1'b0; oe_n = 1'b1; clr = 1'b0; err_clr = 1'b0;
    rd_addr = '0;
    tick(3);
    check_eq("rst_busy", 128'(busy), 128'(1));
    check_eq("rst_err", 128'(err), 128'(0));
    check_eq("rst_wcnt", 128'(window_cnt), 128'(0));
    check_eq("rst_rd", 128'(rd_data), 128'(0));
    rsi_reset_n = 1'b1;
    count_busy("init_busy_len");
    check_mem("init_zero", -1, 0, -1, 0, 1'b0);
    check_eq("init_err", 128'(err), 128'(0));
    check_eq("init_wcnt", 128'(window_cnt), 128'(0));

    // First window: pattern, row 5, 10 cycles.
    load_pattern();
    check_eq("pat_err", 128'(err), 128'(0));
    demux = 3'd5;
    oe_n  = 1'b0;
    tick(10);
    oe_n  = 1'b1;
    tick(65);
    check_eq("w1_wcnt_pre", 128'(window_cnt), 128'(0));
    tick(1);
    check_eq("w1_wcnt", 128'(window_cnt), 128'(1));
    check_mem("w1", 5, 10, -1, 0, 1'b0);

    // Short shift count.
    for (int c = 0; c < 31; c++) shift_col(6'h00);
    strobe();
    tick(1);
    check_eq("short_err", 128'(err), 128'(3'b001));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("errclr", 128'(err), 128'(0));

    // Row 2 window with a strobe in DISPLAY, then a falling edge during UPDATE.
    load_pattern();
    demux = 3'd2;
    oe_n  = 1'b0;
    tick(3);
    rgb_stb = 1'b1;
    tick(1);
    rgb_stb = 1'b0;
    tick(8);
    check_eq("disp_stb_err", 128'(err), 128'(3'b101));
    oe_n = 1'b1;
    tick(20);
    oe_n = 1'b0;
    tick(60);
    oe_n = 1'b1;
    tick(5);
    check_eq("ovr_err", 128'(err), 128'(3'b111));
    check_eq("ovr_wcnt", 128'(window_cnt), 128'(2));
    check_mem("ovr", 5, 10, 2, 12, 1'b0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;

    // clr pulsed during UPDATE.
    demux = 3'd0;
    oe_n  = 1'b0;
    tick(10);
    oe_n  = 1'b1;
    tick(10);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(54);
    check_eq("clr_busy_pre", 128'(busy), 128'(0));
    check_eq("clr_wcnt_pre", 128'(window_cnt), 128'(2));
    tick(1);
    check_eq("clr_busy", 128'(busy), 128'(1));
    check_eq("clr_wcnt", 128'(window_cnt), 128'(3));
    count_busy("clr_busy_len");
    check_mem("clr_zero", -1, 0, -1, 0, 1'b0);

    // All white, two 200-cycle windows on row 0: 8-bit copy saturates.
    for (int c = 0; c < 32; c++) shift_col(6'h3f);
    strobe();
    tick(2);
    for (int w = 0; w < 2; w++) begin
      oe_n = 1'b0;
      tick(200);
      oe_n = 1'b1;
      tick(70);
    end
    check_eq("white_wcnt", 128'(window_cnt), 128'(5));
    check_eq("white_err", 128'(err), 128'(0));
    check_mem("white", 0, 400, -1, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
